// File: rtl/layer_feeder.sv
`default_nettype none
// ============================================================================
// Module      : layer_feeder
// Description : Layer-level driver for a bank of neurons sharing one serial
//               input stream. Accepts a parallel vector, broadcasts its
//               elements one per cycle, collects every neuron's result and
//               presents the collected vector with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_feeder #(
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_NEURONS = 2,
    parameter int WIDTH       = 8
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [NUM_INPUTS*WIDTH-1:0]  IN_VECTOR,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [WIDTH-1:0]             N_VALUE,
    output logic                         N_VALID,
    input  logic [NUM_NEURONS-1:0]       N_READY,
    input  logic [NUM_NEURONS*WIDTH-1:0] N_RESULT,
    input  logic [NUM_NEURONS-1:0]       N_RESULT_VALID,
    input  logic [NUM_NEURONS-1:0]       N_OVERFLOW,
    output logic [NUM_NEURONS*WIDTH-1:0] OUT_VECTOR,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic                         OUT_OVERFLOW
);

    localparam int c_IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_STREAM   = 3'd2,
        S_COLLECT  = 3'd3,
        S_OUTPUT   = 3'd4
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [c_IDX_W-1:0]             r_idx;
    logic [NUM_INPUTS*WIDTH-1:0]    r_vec;
    logic [NUM_NEURONS*WIDTH-1:0]   r_slots;
    logic [NUM_NEURONS-1:0]         r_mask;
    logic [NUM_NEURONS-1:0]         w_mask_next;
    logic                           r_ovf_acc;
    logic                           r_out_ovf;
    logic                           r_first_out;
    logic                           w_accept;
    logic                           w_capture;
    logic                           w_last_elem;
    logic                           w_enter_output;
    logic                           w_ovf_window;
    logic [WIDTH-1:0]               w_elem;

    // Result strobes are honoured while streaming too, since a fast neuron
    // may answer before the last element has gone out.
    assign w_accept       = (r_state == S_IDLE) && IN_VALID;
    assign w_capture      = (r_state == S_STREAM) || (r_state == S_COLLECT);
    assign w_mask_next    = r_mask | (w_capture ? N_RESULT_VALID : '0);
    assign w_last_elem    = (r_idx == c_IDX_W'(NUM_INPUTS - 1));
    assign w_enter_output = (r_state == S_COLLECT) && (w_state_next == S_OUTPUT);
    // The first OUTPUT cycle is included so a neuron's registered flag,
    // which lags its final result by one cycle, is not lost.
    assign w_ovf_window   = w_capture || ((r_state == S_OUTPUT) && r_first_out);

    // Select the element currently addressed by the stream index.
    always_comb begin
        w_elem = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_elem = r_vec[k*WIDTH +: WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake/stream outputs.
    always_comb begin
        w_state_next = r_state;
        IN_READY     = 1'b0;
        N_VALID      = 1'b0;
        N_VALUE      = '0;
        OUT_VALID    = 1'b0;
        case (r_state)
            S_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    w_state_next = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (&N_READY) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                N_VALID = 1'b1;
                N_VALUE = w_elem;
                if (w_last_elem) begin
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (&w_mask_next) begin
                    w_state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Input vector capture and stream index.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_vec <= '0;
            r_idx <= '0;
        end else begin
            if (w_accept) begin
                r_vec <= IN_VECTOR;
            end
            if (r_state == S_STREAM && !w_last_elem) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_idx <= '0;
            end
        end
    end

    // Result slots and capture mask; repeat strobes simply overwrite.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_slots <= '0;
            r_mask  <= '0;
        end else begin
            if (w_accept) begin
                r_mask <= '0;
            end else begin
                r_mask <= w_mask_next;
            end
            for (int j = 0; j < NUM_NEURONS; j++) begin
                if (w_capture && N_RESULT_VALID[j]) begin
                    r_slots[j*WIDTH +: WIDTH] <= N_RESULT[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Overflow accumulation and its publication on entry to OUTPUT.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_ovf_acc   <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_first_out <= 1'b0;
        end else begin
            r_first_out <= w_enter_output;
            if (w_accept) begin
                r_ovf_acc <= 1'b0;
            end else if (w_ovf_window) begin
                r_ovf_acc <= r_ovf_acc | (|N_OVERFLOW);
            end
            if (w_enter_output) begin
                r_out_ovf <= r_ovf_acc | (|N_OVERFLOW);
            end else if ((r_state == S_OUTPUT) && r_first_out) begin
                r_out_ovf <= r_out_ovf | (|N_OVERFLOW);
            end
        end
    end

    assign OUT_VECTOR   = r_slots;
    assign OUT_OVERFLOW = r_out_ovf;

endmodule
`default_nettype wire

// File: doc/layer_feeder.md
Name: layer_feeder

Overview:
- Layer-level driver for a bank of neurons that share one serial input stream.
- Accepts one parallel input vector through a valid/ready handshake.
- Broadcasts the vector's elements serially, one per cycle, on the shared neuron input port, then collects every neuron's result into a parallel output vector.
- Presents that vector upstream of the next layer with a sticky aggregated overflow flag.

Parameters:
- NUM_INPUTS, 2, number of vector elements streamed to each neuron.
- NUM_NEURONS, 2, number of neurons in the layer (results collected).
- WIDTH, 8, fixed-point word width (two's complement; feeder does no arithmetic).

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset.
- IN_VECTOR  in  NUM_INPUTS*WIDTH  input vector; element k at bits [k*WIDTH +: WIDTH].
- IN_VALID  in  1  input vector valid.
- IN_READY  out  1  feeder can accept a vector.
- N_VALUE  out  WIDTH  serial element broadcast to all neurons.
- N_VALID  out  1  N_VALUE qualifier, one element per asserted cycle.
- N_READY  in  NUM_NEURONS  per-neuron idle/ready.
- N_RESULT  in  NUM_NEURONS*WIDTH  per-neuron result; neuron j at bits [j*WIDTH +: WIDTH].
- N_RESULT_VALID  in  NUM_NEURONS  per-neuron one-cycle result strobe.
- N_OVERFLOW  in  NUM_NEURONS  per-neuron overflow flag.
- OUT_VECTOR  out  NUM_NEURONS*WIDTH  collected results, same packing as N_RESULT.
- OUT_VALID  out  1  output vector valid.
- OUT_READY  in  1  downstream accepts.
- OUT_OVERFLOW  out  1  OR of all neuron overflows for this vector.

Behaviour:
- Reset (RSTN, synchronous, active-low; clock CLK): state IDLE, IN_READY=1, N_VALID=0, N_VALUE=0, OUT_VALID=0, OUT_VECTOR=0, OUT_OVERFLOW=0, element index=0, capture mask=0.
  - Reset mid-operation aborts immediately.
  - Partially streamed or partially collected data is discarded.
- States:
  - IDLE: IN_READY=1. On IN_VALID&IN_READY at an edge, register IN_VECTOR, clear capture mask and overflow accumulator, go to WAIT_RDY.
  - WAIT_RDY: IN_READY=0. When N_READY is all ones, go to STREAM. Otherwise hold indefinitely.
  - STREAM: N_VALID=1 for exactly NUM_INPUTS consecutive cycles.
    - N_VALUE = element idx, idx = 0..NUM_INPUTS-1, in ascending order, no bubbles.
    - N_READY is ignored during STREAM.
    - After the last element, go to COLLECT with idx cleared.
  - COLLECT: N_VALID=0.
    - Each cycle, for every j with N_RESULT_VALID[j]=1: capture N_RESULT[j] into slot j and set mask[j].
    - Strobes may arrive in any order, in the same cycle, or already during STREAM; all are captured.
    - A repeat strobe for an already-set slot overwrites the slot and the mask stays set.
    - When the mask is all ones (counting captures made this cycle), go to OUTPUT the next cycle.
  - OUTPUT: OUT_VALID=1, OUT_VECTOR and OUT_OVERFLOW stable.
    - On OUT_VALID&OUT_READY, go to IDLE.
    - OUT_VALID stays high until accepted.
- Overflow accumulator:
  - OR of N_OVERFLOW, sampled every cycle from STREAM entry through the cycle the FSM leaves COLLECT, plus the first OUTPUT cycle (covers the neuron's registered flag).
  - Registered into OUT_OVERFLOW on OUTPUT entry and updated once more on the first OUTPUT cycle.
- Latency: accept at edge t, neurons ready → N_VALID high on cycles t+2 .. t+1+NUM_INPUTS. OUT_VALID rises the cycle after the final result strobe.
- IN_READY is high only in IDLE, so no new vector is accepted until the output has been consumed.
- No throughput overlap.

Test Plan:
- Single vector: WIDTH=8, IN_VECTOR={0x40,0x20}, N_READY=2'b11; neuron model returns 0x11/0x22 after 3 cycles → N_VALUE 0x20 then 0x40 on consecutive cycles; OUT_VECTOR={0x22,0x11}, OUT_OVERFLOW=0.
- Stall: N_READY=2'b01 for 5 cycles after accept → N_VALID stays 0 throughout; streaming starts 1 cycle after N_READY=2'b11.
- Out-of-order and simultaneous results: neuron1 strobes 0x7F at cycle c, neuron0 strobes 0x80 at c+4 → OUT_VALID at c+5, OUT_VECTOR={0x7F,0x80}. Repeat with both strobing the same cycle → OUT_VALID the next cycle.
- Overflow: N_OVERFLOW[1] pulses 1 cycle during COLLECT → OUT_OVERFLOW=1. The next vector without overflow → OUT_OVERFLOW=0.
- Backpressure: OUT_READY=0 for 10 cycles → OUT_VALID and OUT_VECTOR stable, IN_READY=0 even with IN_VALID=1. OUT_READY=1 → IDLE, IN_READY=1 the next cycle.
- Reset mid-STREAM after element 0 → the next cycle shows all outputs at reset values. A fresh vector then completes normally.
